// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- eight-way round-robin arbiter for one shared datapath port.
// The grant is registered as a one-hot vector plus its 3-bit index. The owner
// keeps the grant until it drops its request. Fairness comes from a rotating
// priority pointer that moves only when a grant is released.
// Optional feature: define RR_ARB_TIMEOUT_EN to force a release after HOLD_MAX
// consecutive grant cycles. That build also produces a one-cycle timeout pulse.
// HOLD_MAX is unused while RR_ARB_TIMEOUT_EN is undefined.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  // HOLD_MAX must fit the 8-bit hold counter and be nonzero
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter_8: HOLD_MAX out of range 1..255");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [7:0] gnt_q;
  logic [7:0] gnt_nxt;
  logic [2:0] idx_q;
  logic [2:0] idx_nxt;

  logic       owner_req;
  logic       release_now;
  logic [2:0] scan_start;
  logic [7:0] cand_mask;
  logic [3:0] win;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic       timeout_q;
  logic       timeout_nxt;
  logic       forced;
`endif

  // Returns {found, index} of the first set mask bit scanning start, start+1, ... mod 8.
  // The loop runs from the farthest offset down to the nearest one.
  // The last hit written is therefore the nearest one to start.
  function automatic logic [3:0] pick(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    logic [3:0] res;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = start + k[2:0];
      if (mask[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // State register: holds the FSM state, the pointer, the registered grant and the timeout bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt_q     <= 8'd0;
      idx_q     <= 3'd0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_q     <= gnt_nxt;
      idx_q     <= idx_nxt;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt  <= hold_cnt_nxt;
      timeout_q <= timeout_nxt;
`endif
    end
  end

  // Next-state logic: arbitrate from IDLE, or hold / release / re-arbitrate in GRANT
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt_q;
    idx_nxt     = idx_q;
    owner_req   = req[idx_q];
    release_now = 1'b0;
    scan_start  = ptr;
    cand_mask   = 8'd0;
    win         = 4'b0000;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
    forced       = 1'b0;
`endif

    case (state)
      IDLE: begin
        scan_start = ptr;
        cand_mask  = req;
        win        = pick(cand_mask, scan_start);
        if (win[3]) begin
          state_nxt = GRANT;
          gnt_nxt   = 8'b0000_0001 << win[2:0];
          idx_nxt   = win[2:0];
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_nxt = 8'd1;
`endif
        end
      end

      GRANT: begin
        release_now = !owner_req;
`ifdef RR_ARB_TIMEOUT_EN
        forced      = owner_req && (hold_cnt >= HOLD_LIM);
        release_now = release_now || forced;
`endif
        if (release_now) begin
          scan_start = idx_q + 3'd1;
          ptr_nxt    = scan_start;
          cand_mask  = req & ~gnt_q;
`ifdef RR_ARB_TIMEOUT_EN
          // A forced release lets the old owner compete again
          if (forced) begin
            cand_mask = req;
          end
          timeout_nxt = forced;
`endif
          win = pick(cand_mask, scan_start);
          if (win[3]) begin
            state_nxt = GRANT;
            gnt_nxt   = 8'b0000_0001 << win[2:0];
            idx_nxt   = win[2:0];
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_nxt = 8'd1;
`endif
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 8'd0;
            idx_nxt   = 3'd0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_nxt = 8'd0;
`endif
          end
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_nxt = hold_cnt + 8'd1;
`endif
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 8'd0;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  // Output logic: outputs come only from registers, so there is no path from req to any output
  always_comb begin
    gnt       = gnt_q;
    gnt_idx   = idx_q;
    gnt_valid = |gnt_q;
`ifdef RR_ARB_TIMEOUT_EN
    timeout   = timeout_q;
`else
    timeout   = 1'b0;
`endif
  end

  // The grant must be one-hot or zero, and the index must agree with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q))
        else $error("rr_arbiter_8: grant not one-hot");
      assert (gnt_q == 8'd0 || gnt_q == (8'b0000_0001 << idx_q))
        else $error("rr_arbiter_8: grant and index disagree");
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8 -- directed self-checking bench for rr_arbiter_8.
// Expected values are computed by hand.
// The timeout vectors are compiled in only when RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then wait for one rising edge and settle 1 unit past it
  task automatic applyStimulus(input logic [7:0] new_req, input logic new_rst);
    req = new_req;
    rst = new_rst;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts the check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare all four outputs against one expected grant state
  task automatic checkGrant(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_idx,
                            input logic exp_to);
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    checkOutput({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
    checkOutput({tag, ".valid"}, 32'(gnt_valid), 32'(exp_gnt != 8'd0));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  // Directed vectors
  initial begin
    req = 8'd0;
    rst = 1'b1;

    // Reset state
    applyStimulus(8'h00, 1'b1);
    checkGrant("reset", 8'h00, 3'd0, 1'b0);

    // Single requester: 1-cycle latency, hold, then release to idle (ptr -> 1)
    applyStimulus(8'h01, 1'b0);
    checkGrant("t1.first", 8'h01, 3'd0, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkGrant("t1.hold1", 8'h01, 3'd0, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkGrant("t1.hold2", 8'h01, 3'd0, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkGrant("t1.drop", 8'h00, 3'd0, 1'b0);

    // Back-to-back handoff 0 -> 7, then wrap 7 -> 0
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h81, 1'b0);
    checkGrant("t2.g0", 8'h01, 3'd0, 1'b0);
    applyStimulus(8'h81, 1'b0);
    checkGrant("t2.g0hold", 8'h01, 3'd0, 1'b0);
    applyStimulus(8'h80, 1'b0);
    checkGrant("t2.b2b7", 8'h80, 3'd7, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkGrant("t2.wrap0", 8'h01, 3'd0, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkGrant("t2.idle", 8'h00, 3'd0, 1'b0);

    // Pointer rotation: release 2 sets ptr=3, so 8'h05 picks 0; release 0 sets ptr=1, so 8'h05 picks 2
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h04, 1'b0);
    checkGrant("t3.g2", 8'h04, 3'd2, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkGrant("t3.rel2", 8'h00, 3'd0, 1'b0);
    applyStimulus(8'h05, 1'b0);
    checkGrant("t3.ptr3", 8'h01, 3'd0, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h05, 1'b0);
    checkGrant("t3.ptr1", 8'h04, 3'd2, 1'b0);
    applyStimulus(8'h00, 1'b0);

    // No preemption: owner 5 keeps grant while 1 waits (ptr=3 here)
    applyStimulus(8'h20, 1'b0);
    checkGrant("t4.g5", 8'h20, 3'd5, 1'b0);
    applyStimulus(8'h22, 1'b0);
    checkGrant("t4.hold_a", 8'h20, 3'd5, 1'b0);
    applyStimulus(8'h22, 1'b0);
    checkGrant("t4.hold_b", 8'h20, 3'd5, 1'b0);
    applyStimulus(8'h02, 1'b0);
    checkGrant("t4.to1", 8'h02, 3'd1, 1'b0);
    applyStimulus(8'h00, 1'b0);

    // Move ptr to 5, grant 6, reset mid-grant; 8'h88 must then pick 3 (ptr back to 0)
    applyStimulus(8'h10, 1'b0);
    checkGrant("t5.g4", 8'h10, 3'd4, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h40, 1'b0);
    checkGrant("t5.g6", 8'h40, 3'd6, 1'b0);
    applyStimulus(8'h40, 1'b1);
    checkGrant("t5.rst", 8'h00, 3'd0, 1'b0);
    applyStimulus(8'h88, 1'b0);
    checkGrant("t5.g3", 8'h08, 3'd3, 1'b0);
    applyStimulus(8'h00, 1'b0);

    // One-cycle request pulse still earns a one-cycle grant (ptr=4)
    applyStimulus(8'h10, 1'b0);
    checkGrant("pulse.g4", 8'h10, 3'd4, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkGrant("pulse.rel", 8'h00, 3'd0, 1'b0);

    // Full rotation with all requesting, ptr=5: 5 -> 6 -> 7 -> 0
    applyStimulus(8'hFF, 1'b0);
    checkGrant("rot.g5", 8'h20, 3'd5, 1'b0);
    applyStimulus(8'hDF, 1'b0);
    checkGrant("rot.g6", 8'h40, 3'd6, 1'b0);
    applyStimulus(8'hBF, 1'b0);
    checkGrant("rot.g7", 8'h80, 3'd7, 1'b0);
    applyStimulus(8'h7F, 1'b0);
    checkGrant("rot.g0", 8'h01, 3'd0, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkGrant("rot.idle", 8'h00, 3'd0, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    // HOLD_MAX=4: owner 0 is forced off after 4 cycles, and 1 takes over with a timeout pulse
    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h03, 1'b0);
      checkGrant($sformatf("to.own0_%0d", i), 8'h01, 3'd0, 1'b0);
    end
    applyStimulus(8'h03, 1'b0);
    checkGrant("to.forced1", 8'h02, 3'd1, 1'b1);
    applyStimulus(8'h03, 1'b0);
    checkGrant("to.after1", 8'h02, 3'd1, 1'b0);

    // Sole requester 0: re-granted continuously, with a timeout every 4 cycles
    applyStimulus(8'h01, 1'b0);
    checkGrant("to.solo_start", 8'h01, 3'd0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        applyStimulus(8'h01, 1'b0);
        checkGrant($sformatf("to.solo_hold%0d_%0d", r, i), 8'h01, 3'd0, 1'b0);
      end
      applyStimulus(8'h01, 1'b0);
      checkGrant($sformatf("to.solo_pulse%0d", r), 8'h01, 3'd0, 1'b1);
    end
`else
    // Without the timeout feature, a grant holds indefinitely and timeout stays low
    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h03, 1'b0);
      checkGrant($sformatf("hold.%0d", i), 8'h01, 3'd0, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
